rr_stream_mux: RTL and testbench

Parametrised, registered N-channel, W-bit stream multiplexer with valid/ready handshakes on every input and on the output. In fixed mode an address selects the channel, as the 4:1 combinational multiplexers do. In round-robin mode the block arbitrates fairly among all requesting channels. It sits between several producer streams and a single consumer, and carries a one-entry output register so that the consumer sees registered outputs.

---
 rtl/mux_pkg.sv | 13 +
 rtl/rr_priority_picker.sv | 30 +++
 rtl/rr_stream_mux.sv | 105 ++++++++++
 tb/tb_rr_stream_mux.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: mode encodings
// and the channel-index width rule.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width is at least one bit even for a two-channel mux.
    function automatic int calc_selw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: first requester strictly after ptr,
// wrapping modulo CHANNELS.
module rr_priority_picker
    import mux_pkg::*;
#(
    parameter int   CHANNELS = 4,
    localparam int  SELW     = calc_selw(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     ptr,
    output logic [SELW-1:0]     grant,
    output logic                grant_valid
);

    int idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = (int'(ptr) + k) % CHANNELS;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant       = SELW'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with fixed (address) or round-robin grant
// and a single registered output slot that supports same-cycle pop and push.
module rr_stream_mux
    import mux_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter int   CHANNELS = 4,
    localparam int  SELW     = calc_selw(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SELW-1:0]           address,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_channel
);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SELW-1:0]    out_channel_q, out_channel_d;
    logic [SELW-1:0]    ptr_q, ptr_d;
    logic               run_q, run_d;

    logic [SELW-1:0]    rr_grant, fix_grant, grant;
    logic               rr_valid, fix_valid, grant_valid;
    logic               load;
    logic [WIDTH-1:0]   sel_data;

    rr_priority_picker #(.CHANNELS(CHANNELS)) u_picker (
        .req         (in_valid),
        .ptr         (ptr_q),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    // Out-of-range addresses match no channel and therefore never grant.
    always_comb begin
        fix_grant = address;
        fix_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (address == SELW'(i) && in_valid[i]) begin
                fix_valid = 1'b1;
            end
        end
    end

    always_comb begin
        grant       = (mode == MODE_RR) ? rr_grant : fix_grant;
        grant_valid = (mode == MODE_RR) ? rr_valid : fix_valid;
        // run_q blocks transfers until one full clock after reset release.
        load        = run_q && grant_valid && (state_q == ST_EMPTY || out_ready);
        sel_data    = '0;
        in_ready    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SELW'(i)) begin
                sel_data    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = load;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        ptr_d         = ptr_q;
        run_d         = 1'b1;
        if (load) begin
            state_d       = ST_FULL;
            out_data_d    = sel_data;
            out_channel_d = grant;
            ptr_d         = grant;
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_EMPTY;
            out_data_q    <= '0;
            out_channel_q <= '0;
            ptr_q         <= SELW'(CHANNELS - 1);
            run_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            ptr_q         <= ptr_d;
            run_q         <= run_d;
        end
    end

    assign out_valid   = (state_q == ST_FULL);
    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux: a reference model predicts grants and
// queues expected words; an independent monitor pops and compares outputs.
module tb_rr_stream_mux;
    import mux_pkg::*;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int SELW = calc_selw(N);

    typedef struct packed {
        logic [W-1:0]    data;
        logic [SELW-1:0] ch;
    } item_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              mode = 1'b0;
    logic [SELW-1:0]   address = '0;
    logic [N-1:0]      in_valid = '0;
    logic [N*W-1:0]    in_data = '0;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [W-1:0]      out_data;
    logic [SELW-1:0]   out_channel;

    item_t sb[$];
    int    glog[$];
    int    exp_q[$];
    int    ptr_m = N - 1;
    bit    armed = 1'b0;
    int    n_checks = 0;
    int    n_fail = 0;

    rr_stream_mux #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .address     (address),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_channel (out_channel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference grant rule: fixed picks the addressed channel if it requests,
    // round-robin scans channels ptr+1, ptr+2, ... wrapping around.
    function automatic int model_grant(input logic m, input int a, input logic [N-1:0] v, input int p);
        if (m == MODE_FIXED) begin
            if (a < N && v[a]) return a;
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N*W-1:0] seq_data(input logic [W-1:0] base);
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = base + W'(i);
        return d;
    endfunction

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
        return d;
    endfunction

    task automatic step(input logic m, input logic [SELW-1:0] a, input logic [N-1:0] v,
                        input logic o, input logic [N*W-1:0] d);
        int  g;
        bit  ld;
        logic [N-1:0] exp_rdy;
        item_t it;
        @(negedge clk);
        mode = m; address = a; in_valid = v; out_ready = o; in_data = d;
        #1;
        g  = model_grant(m, int'(a), v, ptr_m);
        ld = armed && (g >= 0) && (sb.size() == 0 || o);
        exp_rdy = '0;
        if (ld) exp_rdy[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        for (int i = 0; i < N; i++) if (in_ready[i]) glog.push_back(i);
        @(posedge clk);
        #1;
        if (ld) begin
            it.data = d[g*W +: W];
            it.ch   = SELW'(g);
            sb.push_back(it);
            ptr_m = g;
        end
        armed = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        sb.delete();
        ptr_m = N - 1;
        armed = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_channel", 64'(out_channel), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        armed = 1'b1;
    endtask

    task automatic chk_seq(input string name);
        chk({name, "_len"}, 64'(glog.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < glog.size(); i++)
            chk(name, 64'(glog[i]), 64'(exp_q[i]));
    endtask

    // Monitor: compares the presented word against the scoreboard head and
    // retires it when the consumer accepts.
    initial begin : monitor
        bit pop;
        forever begin
            @(negedge clk);
            #2;
            pop = 1'b0;
            if (!reset) begin
                chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
                if (out_valid && sb.size() > 0) begin
                    chk("out_data", 64'(out_data), 64'(sb[0].data));
                    chk("out_channel", 64'(out_channel), 64'(sb[0].ch));
                end
                pop = out_valid && out_ready;
            end
            @(posedge clk);
            #1;
            if (pop && sb.size() > 0) void'(sb.pop_front());
        end
    end

    initial begin : stimulus
        int cnt;
        do_reset();

        for (int i = 0; i < 10; i++) step(MODE_FIXED, '0, '0, 1'b1, rand_data());
        chk("idle_out_data", 64'(out_data), 64'(0));
        chk("idle_out_channel", 64'(out_channel), 64'(0));
        chk("idle_no_grant", 64'(glog.size()), 64'(0));

        glog.delete();
        for (int i = 0; i < 6; i++) step(MODE_FIXED, SELW'(2), 4'b1111, 1'b1, seq_data(8'hA0));
        exp_q = '{2, 2, 2, 2, 2, 2};
        chk_seq("fixed_addr2");
        chk("fixed_out_data", 64'(out_data), 64'(8'hA2));

        do_reset();
        glog.delete();
        for (int i = 0; i < 8; i++) step(MODE_RR, '0, 4'b1111, 1'b1, rand_data());
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk_seq("rr_all");
        for (int b = 0; b < N; b++) begin
            cnt = 0;
            foreach (glog[i]) if (glog[i] == b) cnt++;
            chk("rr_fair", 64'(cnt), 64'(2));
        end

        glog.delete();
        for (int i = 0; i < 4; i++) step(MODE_RR, '0, 4'b1010, 1'b1, rand_data());
        exp_q = '{1, 3, 1, 3};
        chk_seq("rr_1010");
        glog.delete();
        for (int i = 0; i < 4; i++) step(MODE_RR, '0, 4'b0010, 1'b1, rand_data());
        exp_q = '{1, 1, 1, 1};
        chk_seq("rr_ch1_only");

        step(MODE_FIXED, '0, 4'b0001, 1'b1, seq_data(8'h55));
        for (int i = 0; i < 5; i++) begin
            step(MODE_FIXED, '0, 4'b0001, 1'b0, seq_data(8'h66));
            chk("bp_hold", 64'(out_data), 64'(8'h55));
        end
        step(MODE_FIXED, '0, 4'b0001, 1'b1, seq_data(8'h66));
        chk("bp_no_bubble_valid", 64'(out_valid), 64'(1));
        chk("bp_no_bubble_data", 64'(out_data), 64'(8'h66));

        glog.delete();
        step(MODE_RR, '0, 4'b1111, 1'b1, rand_data());
        step(MODE_RR, '0, 4'b1111, 1'b1, rand_data());
        exp_q = '{1, 2};
        chk_seq("pre_reset");
        do_reset();
        glog.delete();
        step(MODE_RR, '0, 4'b1111, 1'b1, rand_data());
        exp_q = '{0};
        chk_seq("post_reset_first");

        for (int i = 0; i < 400; i++)
            step(logic'($urandom_range(0, 1)), SELW'($urandom), N'($urandom),
                 logic'($urandom_range(0, 3) != 0), rand_data());

        for (int i = 0; i < 3; i++) step(MODE_RR, '0, '0, 1'b1, rand_data());
        chk("drained", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
